ol_layer_sequencer: RTL
=======================

# ol_layer_sequencer

Sequences one output layer of `OL_NEURON` instances through a single inference pass. It accepts a start request from upstream, waits until every neuron reports ready, and fires a single broadcast `VALID_IN`. It then collects each neuron's result as it arrives and presents the full layer vector downstream under a valid/ready handshake. It sits between the layer-input driver and the next layer (or output stage), and aggregates neuron overflow into one sticky layer flag.

## Interface
- `NUM_NEURONS`, 8, number of neurons sequenced (1..32)
- `WIDTH`, 8, neuron output width
- `TIMEOUT_CYCLES`, 255, collect-phase watchdog limit; used only with `OL_LAYER_SEQ_TIMEOUT_EN`
- `CLK` in 1: clock
- `RSTN` in 1: reset, synchronous, active-low
- `START` in 1: request one pass; accepted only while `START_READY`=1
- `START_READY` out 1: high in IDLE only
- `NEURON_READY` in NUM_NEURONS: per-neuron `READY`
- `NEURON_VALID_IN` out 1: broadcast start pulse to all neurons
- `NEURON_VALID_OUT` in NUM_NEURONS: per-neuron `VALID_OUT` pulses
- `NEURON_VALUE_OUT` in NUM_NEURONS*WIDTH: neuron i at `[i*WIDTH +: WIDTH]`
- `NEURON_OVERFLOW` in NUM_NEURONS: per-neuron `OVERFLOW`
- `LAYER_VALUE_OUT` out NUM_NEURONS*WIDTH: captured layer vector, same packing
- `LAYER_VALID` out 1: result available; held until accepted
- `LAYER_READY` in 1: downstream accept
- `LAYER_OVERFLOW` out 1: OR of overflows seen this pass
- `TIMEOUT` out 1: pass ended by the watchdog (always 0 when the macro is off)
- `BUSY` out 1: state != IDLE

## Operation
- States: IDLE, WAIT_RDY, FIRE, COLLECT, HOLD.
- IDLE, on `START`=1:
  - go to WAIT_RDY.
  - clear `done_mask`, `LAYER_VALUE_OUT`, `LAYER_OVERFLOW` and `TIMEOUT`.
- WAIT_RDY: when `&NEURON_READY`=1, go to FIRE. Otherwise remain indefinitely.
- FIRE: `NEURON_VALID_IN`=1 for exactly this one cycle, then go to COLLECT.
- COLLECT: for each i with `NEURON_VALID_OUT[i]`=1 and `done_mask[i]`=0:
  - capture `NEURON_VALUE_OUT[i]` into lane i and set `done_mask[i]`.
  - OR `NEURON_OVERFLOW[i]` into `LAYER_OVERFLOW`.
- COLLECT exit: when the next-cycle `done_mask` is all ones, go to HOLD. Multiple neurons may complete in the same cycle; all are captured.
- Repeat `VALID_OUT` from an already-done neuron is ignored; the first capture is kept.
- `NEURON_VALID_OUT` outside COLLECT is ignored.
- HOLD: `LAYER_VALID`=1 and outputs stable. On `LAYER_READY`=1, go to IDLE.
- `START` outside IDLE is ignored; no queuing.
- `NEURON_READY` is not monitored after FIRE.
- Reset, including mid-pass:
  - go to IDLE.
  - `START_READY`=1; `NEURON_VALID_IN`, `LAYER_VALID`, `LAYER_OVERFLOW`, `TIMEOUT`, `BUSY` all =0.
  - `LAYER_VALUE_OUT`=0 and `done_mask`=0.

## Timing
- All outputs are registered except `START_READY` and `BUSY`, which are decoded from the state.
- `START` sampled at edge T (IDLE): WAIT_RDY at T+1.
- With all neurons ready, `NEURON_VALID_IN` is high during cycle T+2.
- COLLECT begins at T+3.
- Last `VALID_OUT` sampled at edge C: `LAYER_VALID`=1 from C+1, and `LAYER_VALUE_OUT` is valid in the same cycle.
- Handshake completes at the edge where `LAYER_VALID`&&`LAYER_READY`; `START_READY`=1 the next cycle.
- Minimum IDLE-to-IDLE overhead is 4 cycles plus neuron latency plus downstream stall.
- No back-to-back pass overlap.

## Configuration
- `OL_LAYER_SEQ_TIMEOUT_EN` defined:
  - an 8..16-bit counter clears on COLLECT entry and increments each COLLECT cycle.
  - if no exit has occurred when the counter reaches `TIMEOUT_CYCLES`, go to HOLD with `TIMEOUT`=1.
  - lanes not yet captured stay 0.
  - a completion in the same cycle as expiry takes priority: `TIMEOUT`=0.
- Macro undefined: no counter; `TIMEOUT` tied to 0; COLLECT waits forever.

## Test plan
- Basic pass, NUM_NEURONS=8:
  - stimulus: all ready; `START` pulse; neuron i returns value i+1 at cycle 5+i after FIRE.
  - response: one `NEURON_VALID_IN` pulse; `LAYER_VALID` the cycle after neuron 7; lanes 1..8; `LAYER_OVERFLOW`=0.
- Ready stall:
  - stimulus: `NEURON_READY[3]`=0 for 10 cycles after `START`.
  - response: `NEURON_VALID_IN` fires 1 cycle after bit 3 rises, never earlier.
- Simultaneous and duplicate completions:
  - stimulus: all 8 `VALID_OUT` in one cycle, then neuron 0 again with 0x7F.
  - response: HOLD the next cycle; lane 0 keeps its first value.
- Overflow and backpressure:
  - stimulus: neuron 2 returns with `OVERFLOW`=1; `LAYER_READY`=0 for 20 cycles.
  - response: `LAYER_OVERFLOW`=1, outputs stable for 20 cycles; IDLE after accept; next pass clears the flag.
- Reset mid-COLLECT:
  - stimulus: `RSTN`=0 for 1 cycle after 3 of 8 neurons complete.
  - response: all outputs at reset values; `START_READY`=1 the next cycle.
- With `OL_LAYER_SEQ_TIMEOUT_EN`, `TIMEOUT_CYCLES`=20:
  - stimulus: neuron 5 never responds.
  - response: HOLD 20 cycles after COLLECT entry; `TIMEOUT`=1; lane 5 =0.

Source files
------------

// File: rtl/ol_layer_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : ol_layer_sequencer_if
// Purpose  : Bundles the start, neuron-array and layer-result signals of
//            ol_layer_sequencer.
//            master : sequencer side (drives START_READY, NEURON_VALID_IN,
//                     LAYER_*, TIMEOUT, BUSY)
//            slave  : environment side (upstream driver, neuron array and
//                     downstream consumer)
// Ports    : START / START_READY          upstream start handshake
//            NEURON_READY / NEURON_VALID_IN / NEURON_VALID_OUT /
//            NEURON_VALUE_OUT / NEURON_OVERFLOW   neuron array
//            LAYER_VALUE_OUT / LAYER_VALID / LAYER_READY /
//            LAYER_OVERFLOW               downstream result handshake
//            TIMEOUT, BUSY                status
// Revision : 1.0 - initial release
// ============================================================================
interface ol_layer_sequencer_if #(
    parameter int NUM_NEURONS = 8,
    parameter int WIDTH       = 8
);
    logic                         START;
    logic                         START_READY;
    logic [NUM_NEURONS-1:0]       NEURON_READY;
    logic                         NEURON_VALID_IN;
    logic [NUM_NEURONS-1:0]       NEURON_VALID_OUT;
    logic [NUM_NEURONS*WIDTH-1:0] NEURON_VALUE_OUT;
    logic [NUM_NEURONS-1:0]       NEURON_OVERFLOW;
    logic [NUM_NEURONS*WIDTH-1:0] LAYER_VALUE_OUT;
    logic                         LAYER_VALID;
    logic                         LAYER_READY;
    logic                         LAYER_OVERFLOW;
    logic                         TIMEOUT;
    logic                         BUSY;

    modport master (
        input  START, NEURON_READY, NEURON_VALID_OUT, NEURON_VALUE_OUT,
               NEURON_OVERFLOW, LAYER_READY,
        output START_READY, NEURON_VALID_IN, LAYER_VALUE_OUT, LAYER_VALID,
               LAYER_OVERFLOW, TIMEOUT, BUSY
    );

    modport slave (
        output START, NEURON_READY, NEURON_VALID_OUT, NEURON_VALUE_OUT,
               NEURON_OVERFLOW, LAYER_READY,
        input  START_READY, NEURON_VALID_IN, LAYER_VALUE_OUT, LAYER_VALID,
               LAYER_OVERFLOW, TIMEOUT, BUSY
    );
endinterface
`default_nettype wire

// File: rtl/ol_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ol_layer_sequencer
// Purpose  : Runs one output layer of neurons through a single inference
//            pass: waits for all neurons ready, fires one broadcast
//            NEURON_VALID_IN, collects every neuron result (first capture
//            per lane wins) and holds the layer vector under a valid/ready
//            handshake. Neuron overflows are ORed into a sticky layer flag.
// Ports    : CLK  - clock
//            RSTN - synchronous active-low reset
//            bus  - ol_layer_sequencer_if.master (start handshake, neuron
//                   array, layer result handshake, TIMEOUT, BUSY)
// Options  : `define OL_LAYER_SEQ_TIMEOUT_EN adds a collect-phase watchdog
//            that ends the pass after TIMEOUT_CYCLES cycles in COLLECT.
// Revision : 1.0 - initial release
// ============================================================================
module ol_layer_sequencer #(
    parameter int NUM_NEURONS    = 8,
    parameter int WIDTH          = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic              CLK,
    input  wire logic              RSTN,
    ol_layer_sequencer_if.master   bus
);

    // Elaboration-time parameter legality check.
    if (NUM_NEURONS < 1 || NUM_NEURONS > 32 || WIDTH < 1 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("ol_layer_sequencer: parameter out of range");
    end

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_RDY = 3'd1,
        ST_FIRE     = 3'd2,
        ST_COLLECT  = 3'd3,
        ST_HOLD     = 3'd4
    } state_t;

    state_t                       r_state;
    state_t                       w_next;
    logic [NUM_NEURONS-1:0]       r_done;
    logic [NUM_NEURONS-1:0]       w_new;
    logic [NUM_NEURONS-1:0]       w_done_next;
    logic [NUM_NEURONS*WIDTH-1:0] r_value;
    logic                         r_ovf;
    logic                         r_valid_in;
    logic                         r_layer_valid;
    logic                         w_start_acc;

    assign w_start_acc = (r_state == ST_IDLE) && bus.START;

`ifdef OL_LAYER_SEQ_TIMEOUT_EN
    localparam logic [15:0] C_TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] r_tcnt;
    logic        r_timeout;
    logic        w_expire;
`endif

    // Next-state decode. w_new holds lanes completing for the first time;
    // it is only non-zero in COLLECT so stray VALID_OUTs are ignored.
    always_comb begin
        w_next      = r_state;
        w_new       = '0;
        w_done_next = r_done;
`ifdef OL_LAYER_SEQ_TIMEOUT_EN
        w_expire    = 1'b0;
`endif
        case (r_state)
            ST_IDLE:     if (bus.START) w_next = ST_WAIT_RDY;
            ST_WAIT_RDY: if (&bus.NEURON_READY) w_next = ST_FIRE;
            ST_FIRE:     w_next = ST_COLLECT;
            ST_COLLECT: begin
                w_new       = bus.NEURON_VALID_OUT & ~r_done;
                w_done_next = r_done | w_new;
                // A completion in the expiry cycle wins over the watchdog.
                if (&w_done_next) begin
                    w_next = ST_HOLD;
                end
`ifdef OL_LAYER_SEQ_TIMEOUT_EN
                else if (r_tcnt == C_TIMEOUT_LAST) begin
                    w_next   = ST_HOLD;
                    w_expire = 1'b1;
                end
`endif
            end
            ST_HOLD:     if (bus.LAYER_READY) w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_state       <= ST_IDLE;
            r_done        <= '0;
            r_value       <= '0;
            r_ovf         <= 1'b0;
            r_valid_in    <= 1'b0;
            r_layer_valid <= 1'b0;
        end else begin
            r_state       <= w_next;
            // Registered outputs are decoded from the next state so they
            // line up with the state they belong to.
            r_valid_in    <= (w_next == ST_FIRE);
            r_layer_valid <= (w_next == ST_HOLD);
            if (w_start_acc) begin
                r_done  <= '0;
                r_value <= '0;
                r_ovf   <= 1'b0;
            end else if (r_state == ST_COLLECT) begin
                r_done <= w_done_next;
                r_ovf  <= r_ovf | (|(w_new & bus.NEURON_OVERFLOW));
                for (int i = 0; i < NUM_NEURONS; i++) begin
                    if (w_new[i]) begin
                        r_value[i*WIDTH +: WIDTH] <= bus.NEURON_VALUE_OUT[i*WIDTH +: WIDTH];
                    end
                end
            end
        end
    end

`ifdef OL_LAYER_SEQ_TIMEOUT_EN
    // Watchdog: zeroed in FIRE so it reads 0 on the first COLLECT cycle.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_tcnt    <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state == ST_FIRE) begin
                r_tcnt <= '0;
            end else if (r_state == ST_COLLECT) begin
                r_tcnt <= r_tcnt + 16'd1;
            end
            if (w_start_acc) begin
                r_timeout <= 1'b0;
            end else if (w_expire) begin
                r_timeout <= 1'b1;
            end
        end
    end
    assign bus.TIMEOUT = r_timeout;
`else
    assign bus.TIMEOUT = 1'b0;
`endif

    assign bus.START_READY     = (r_state == ST_IDLE);
    assign bus.BUSY            = (r_state != ST_IDLE);
    assign bus.NEURON_VALID_IN = r_valid_in;
    assign bus.LAYER_VALID     = r_layer_valid;
    assign bus.LAYER_VALUE_OUT = r_value;
    assign bus.LAYER_OVERFLOW  = r_ovf;

endmodule
`default_nettype wire
